// File: rtl/card_shoe.sv
// ---------------------------------------------------------------------------
// card_shoe -- multi-deck card shoe with in-hardware Fisher-Yates shuffle.
//
// The shoe holds NUM_DECKS x 52 cards. After reset (or a shuffle request)
// the shoe is filled in deck order and then shuffled using an LFSR. Once
// ready, cards are dealt one per request with a one-cycle latency.
//
// Each entry is stored as {suit[1:0], rank0[3:0]} with rank0 = 0..12.
//
// Optional build macro:
//   CARD_SHOE_BYPASS_SHUFFLE_EN - skip the shuffle; cards deal in fill order.
//
// Parameters:
//   NUM_DECKS - decks in the shoe, 1..8
//   LFSR_W    - LFSR width, 6..20 and >= $clog2(52*NUM_DECKS)
//   SEED      - LFSR reset value, non-zero
//   CUT_POS   - dealt-card count at which cut_reached asserts
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   shuffle_req  in   refill and reshuffle (honoured only while ready)
//   deal_req     in   request one card (honoured only while ready)
//   deal_valid   out  one-cycle pulse, card outputs updated
//   deal_err     out  one-cycle pulse, deal requested from an empty shoe
//   card_rank    out  1..13 (1 = ace, 11 = J, 12 = Q, 13 = K)
//   card_suit    out  0 = clubs, 1 = diamonds, 2 = hearts, 3 = spades
//   card_value   out  blackjack points 1..10
//   cards_left   out  undealt cards
//   cut_reached  out  dealt count has reached CUT_POS
//   ready        out  shoe shuffled and accepting requests
// ---------------------------------------------------------------------------
module card_shoe #(
    parameter int                NUM_DECKS = 1,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
    parameter int                CUT_POS   = (52 * NUM_DECKS * 3) / 4,
    localparam int               SHOE_SIZE = 52 * NUM_DECKS,
    localparam int               IDX_W     = $clog2(SHOE_SIZE)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           shuffle_req,
    input  logic           deal_req,
    output logic           deal_valid,
    output logic           deal_err,
    output logic [3:0]     card_rank,
    output logic [1:0]     card_suit,
    output logic [3:0]     card_value,
    output logic [IDX_W:0] cards_left,
    output logic           cut_reached,
    output logic           ready
);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_SHUFFLE = 2'd1,
        ST_READY   = 2'd2
    } state_e;

    // Maximal-length feedback masks (bit n-1 set for tap n).
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            6:       lfsr_taps = 32'h0000_0030;
            7:       lfsr_taps = 32'h0000_0060;
            8:       lfsr_taps = 32'h0000_00B8;
            9:       lfsr_taps = 32'h0000_0110;
            10:      lfsr_taps = 32'h0000_0240;
            11:      lfsr_taps = 32'h0000_0500;
            12:      lfsr_taps = 32'h0000_0829;
            13:      lfsr_taps = 32'h0000_100D;
            14:      lfsr_taps = 32'h0000_2015;
            15:      lfsr_taps = 32'h0000_6000;
            17:      lfsr_taps = 32'h0001_2000;
            18:      lfsr_taps = 32'h0002_0400;
            19:      lfsr_taps = 32'h0004_0023;
            20:      lfsr_taps = 32'h0009_0000;
            default: lfsr_taps = 32'h0000_D008;
        endcase
    endfunction

    localparam logic [31:0]       TAPS_ALL = lfsr_taps(LFSR_W);
    localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SHOE_SIZE - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]    SHOE_CNT = (IDX_W + 1)'(SHOE_SIZE);
    localparam logic [IDX_W:0]    CUT_CNT  = (IDX_W + 1)'(CUT_POS);
    localparam logic [IDX_W:0]    CNT_ONE  = (IDX_W + 1)'(1);

    logic [5:0] shoe_mem [SHOE_SIZE];

    state_e            state_q,      state_d;
    logic [LFSR_W-1:0] lfsr_q,       lfsr_d;
    logic [IDX_W-1:0]  fill_idx_q,   fill_idx_d;
    logic [3:0]        fill_rank_q,  fill_rank_d;
    logic [1:0]        fill_suit_q,  fill_suit_d;
    logic [IDX_W-1:0]  shuf_i_q,     shuf_i_d;
    logic [IDX_W-1:0]  deal_ptr_q,   deal_ptr_d;
    logic [IDX_W:0]    cards_left_q, cards_left_d;
    logic              cut_q,        cut_d;
    logic              valid_q,      valid_d;
    logic              err_q,        err_d;
    logic [3:0]        rank_q,       rank_d;
    logic [1:0]        suit_q,       suit_d;
    logic [3:0]        value_q,      value_d;

    logic             fill_we;
    logic             swap_en;
    logic [IDX_W-1:0] swap_j;
    logic [5:0]       deal_entry;
    logic [IDX_W:0]   dealt_after;

    assign swap_j      = lfsr_q[IDX_W-1:0];
    assign deal_entry  = shoe_mem[deal_ptr_q];
    assign dealt_after = SHOE_CNT - cards_left_q + CNT_ONE;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        fill_idx_d   = fill_idx_q;
        fill_rank_d  = fill_rank_q;
        fill_suit_d  = fill_suit_q;
        shuf_i_d     = shuf_i_q;
        deal_ptr_d   = deal_ptr_q;
        cards_left_d = cards_left_q;
        cut_d        = cut_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        rank_d       = rank_q;
        suit_d       = suit_q;
        value_d      = value_q;
        fill_we      = 1'b0;
        swap_en      = 1'b0;

        case (state_q)
            ST_FILL: begin
                fill_we    = 1'b1;
                fill_idx_d = fill_idx_q + IDX_ONE;
                // Rank counts 0..12, then rolls into the next suit; the
                // 2-bit suit wraps naturally between decks.
                if (fill_rank_q == 4'd12) begin
                    fill_rank_d = 4'd0;
                    fill_suit_d = fill_suit_q + 2'd1;
                end else begin
                    fill_rank_d = fill_rank_q + 4'd1;
                end
                if (fill_idx_q == LAST_IDX) begin
`ifdef CARD_SHOE_BYPASS_SHUFFLE_EN
                    state_d      = ST_READY;
                    deal_ptr_d   = '0;
                    cards_left_d = SHOE_CNT;
                    cut_d        = 1'b0;
`else
                    state_d  = ST_SHUFFLE;
                    shuf_i_d = LAST_IDX;
`endif
                end
            end

            ST_SHUFFLE: begin
                // Rejection sampling: an out-of-range j just waits for the
                // next LFSR value, keeping the permutation unbiased.
                if (swap_j <= shuf_i_q) begin
                    swap_en  = 1'b1;
                    shuf_i_d = shuf_i_q - IDX_ONE;
                    if (shuf_i_q == IDX_ONE) begin
                        state_d      = ST_READY;
                        deal_ptr_d   = '0;
                        cards_left_d = SHOE_CNT;
                        cut_d        = 1'b0;
                    end
                end
            end

            ST_READY: begin
                if (shuffle_req) begin
                    state_d      = ST_FILL;
                    fill_idx_d   = '0;
                    fill_rank_d  = 4'd0;
                    fill_suit_d  = 2'd0;
                    cards_left_d = '0;
                    cut_d        = 1'b0;
                end else if (deal_req) begin
                    if (cards_left_q != '0) begin
                        valid_d      = 1'b1;
                        rank_d       = deal_entry[3:0] + 4'd1;
                        suit_d       = deal_entry[5:4];
                        value_d      = (deal_entry[3:0] <= 4'd9) ? deal_entry[3:0] + 4'd1 : 4'd10;
                        deal_ptr_d   = deal_ptr_q + IDX_ONE;
                        cards_left_d = cards_left_q - CNT_ONE;
                        if (dealt_after >= CUT_CNT) begin
                            cut_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            lfsr_q       <= SEED;
            fill_idx_q   <= '0;
            fill_rank_q  <= 4'd0;
            fill_suit_q  <= 2'd0;
            shuf_i_q     <= '0;
            deal_ptr_q   <= '0;
            cards_left_q <= '0;
            cut_q        <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            rank_q       <= 4'd0;
            suit_q       <= 2'd0;
            value_q      <= 4'd0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            fill_idx_q   <= fill_idx_d;
            fill_rank_q  <= fill_rank_d;
            fill_suit_q  <= fill_suit_d;
            shuf_i_q     <= shuf_i_d;
            deal_ptr_q   <= deal_ptr_d;
            cards_left_q <= cards_left_d;
            cut_q        <= cut_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            rank_q       <= rank_d;
            suit_q       <= suit_d;
            value_q      <= value_d;
        end
    end

    // NOTE: the shoe storage is deliberately not reset; FILL rewrites every
    // entry before anything reads it, so a reset would only cost logic.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            shoe_mem[fill_idx_q] <= {fill_suit_q, fill_rank_q};
        end else if (swap_en) begin
            shoe_mem[shuf_i_q] <= shoe_mem[swap_j];
            shoe_mem[swap_j]   <= shoe_mem[shuf_i_q];
        end
    end

    assign deal_valid  = valid_q;
    assign deal_err    = err_q;
    assign card_rank   = rank_q;
    assign card_suit   = suit_q;
    assign card_value  = value_q;
    assign cards_left  = cards_left_q;
    assign cut_reached = cut_q;
    assign ready       = (state_q == ST_READY);

endmodule
